// File: rtl/check_result_logger.sv
// Statistics and error-record logger behind the trace-format checker: saturating
// record counters plus a show-ahead FIFO of erroneous records. Define LOGGER_ERR_HIST_EN for per-bit error histograms.
module check_result_logger #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       format_type,
  input  logic [3:0]       error_code,
  input  logic             clr,
  input  logic             rd_en,
  output logic [IDX_W+5:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic [IDX_W-1:0] rec_cnt,
  output logic [IDX_W-1:0] reg_cnt,
  output logic [IDX_W-1:0] mem_cnt,
  output logic [IDX_W-1:0] err_cnt
`ifdef LOGGER_ERR_HIST_EN
  ,
  output logic [IDX_W-1:0] err_hist0,
  output logic [IDX_W-1:0] err_hist1,
  output logic [IDX_W-1:0] err_hist2,
  output logic [IDX_W-1:0] err_hist3
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = IDX_W + 6;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    FT_NONE = 2'd0,
    FT_REG  = 2'd1,
    FT_MEM  = 2'd2,
    FT_RSVD = 2'd3
  } fmt_e;

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v == '1) ? v : v + IDX_ONE;
  endfunction

  logic wipe;
  logic rec_valid;
  logic rec_err;
  logic do_push;
  logic do_pop;

  logic [IDX_W-1:0] rec_cnt_q, rec_cnt_d;
  logic [IDX_W-1:0] reg_cnt_q, reg_cnt_d;
  logic [IDX_W-1:0] mem_cnt_q, mem_cnt_d;
  logic [IDX_W-1:0] err_cnt_q, err_cnt_d;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full_now;
  logic          empty_now;

  // Reset and soft clear are indistinguishable; both also swallow the record of that cycle.
  always_comb begin
    wipe      = reset | clr;
    rec_valid = !wipe && (format_type == FT_REG || format_type == FT_MEM);
    rec_err   = rec_valid && (error_code != 4'd0);
    full_now  = (count_q == FULL_CNT);
    empty_now = (count_q == '0);
    do_pop    = !wipe && rd_en && !empty_now;
    do_push   = rec_err && (!full_now || rd_en);
  end

  always_comb begin
    rec_cnt_d = rec_cnt_q;
    reg_cnt_d = reg_cnt_q;
    mem_cnt_d = mem_cnt_q;
    err_cnt_d = err_cnt_q;
    if (rec_valid) begin
      rec_cnt_d = sat_inc(rec_cnt_q);
      if (format_type == FT_REG) reg_cnt_d = sat_inc(reg_cnt_q);
      else                       mem_cnt_d = sat_inc(mem_cnt_q);
      if (rec_err) err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = overflow_q | (rec_err && full_now && !rd_en);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk) begin
    if (wipe) begin
      rec_cnt_q  <= '0;
      reg_cnt_q  <= '0;
      mem_cnt_q  <= '0;
      err_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rec_cnt_q  <= rec_cnt_d;
      reg_cnt_q  <= reg_cnt_d;
      mem_cnt_q  <= mem_cnt_d;
      err_cnt_q  <= err_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; rd_data is forced to zero
  // while empty, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {rec_cnt_q, format_type, error_code};
  end

  assign rd_data  = empty_now ? '0 : mem_q[rd_ptr_q];
  assign empty    = empty_now;
  assign full     = full_now;
  assign overflow = overflow_q;
  assign rec_cnt  = rec_cnt_q;
  assign reg_cnt  = reg_cnt_q;
  assign mem_cnt  = mem_cnt_q;
  assign err_cnt  = err_cnt_q;

`ifdef LOGGER_ERR_HIST_EN
  logic [IDX_W-1:0] hist_q [4];
  logic [IDX_W-1:0] hist_d [4];

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      hist_d[b] = hist_q[b];
      if (rec_valid && error_code[b]) hist_d[b] = sat_inc(hist_q[b]);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wipe) hist_q[b] <= '0;
      else      hist_q[b] <= hist_d[b];
    end
  end

  assign err_hist0 = hist_q[0];
  assign err_hist1 = hist_q[1];
  assign err_hist2 = hist_q[2];
  assign err_hist3 = hist_q[3];
`endif

endmodule

// File: tb/tb_check_result_logger.sv
// Directed bench for check_result_logger: counters, FIFO ordering, full/empty
// corner cases, overflow, clear, saturation and (when enabled) error histograms.
module tb_check_result_logger;

  localparam int DEPTH = 8;
  localparam int IDX_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       format_type;
  logic [3:0]       error_code;
  logic             clr;
  logic             rd_en;
  logic [IDX_W+5:0] rd_data;
  logic             empty;
  logic             full;
  logic             overflow;
  logic [IDX_W-1:0] rec_cnt;
  logic [IDX_W-1:0] reg_cnt;
  logic [IDX_W-1:0] mem_cnt;
  logic [IDX_W-1:0] err_cnt;
`ifdef LOGGER_ERR_HIST_EN
  logic [IDX_W-1:0] err_hist0;
  logic [IDX_W-1:0] err_hist1;
  logic [IDX_W-1:0] err_hist2;
  logic [IDX_W-1:0] err_hist3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  check_result_logger #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .format_type (format_type),
    .error_code  (error_code),
    .clr         (clr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .rec_cnt     (rec_cnt),
    .reg_cnt     (reg_cnt),
    .mem_cnt     (mem_cnt),
    .err_cnt     (err_cnt)
`ifdef LOGGER_ERR_HIST_EN
    ,
    .err_hist0   (err_hist0),
    .err_hist1   (err_hist1),
    .err_hist2   (err_hist2),
    .err_hist3   (err_hist3)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] rec, input logic [15:0] rg,
                           input logic [15:0] mm, input logic [15:0] er);
    check({tag, ".rec_cnt"}, 32'(rec_cnt), 32'(rec));
    check({tag, ".reg_cnt"}, 32'(reg_cnt), 32'(rg));
    check({tag, ".mem_cnt"}, 32'(mem_cnt), 32'(mm));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(er));
  endtask

  // One clock: inputs applied at a falling edge, outputs observed at the next falling edge.
  task automatic cyc(input logic [1:0] ft, input logic [3:0] ec, input logic rd, input logic c);
    format_type = ft;
    error_code  = ec;
    rd_en       = rd;
    clr         = c;
    @(negedge clk);
    format_type = 2'd0;
    error_code  = 4'd0;
    rd_en       = 1'b0;
    clr         = 1'b0;
  endtask

  function automatic logic [31:0] ent(input logic [15:0] idx, input logic [1:0] ft,
                                      input logic [3:0] ec);
    return {10'b0, idx, ft, ec};
  endfunction

  initial begin
    reset       = 1'b1;
    format_type = 2'd0;
    error_code  = 4'd0;
    clr         = 1'b0;
    rd_en       = 1'b0;

    // Reset with a record and a pop present: both must be ignored.
    cyc(2'd1, 4'b0001, 1'b1, 1'b0);
    cyc(2'd2, 4'b0010, 1'b0, 1'b0);
    reset = 1'b0;
    check_cnt("reset", 16'd0, 16'd0, 16'd0, 16'd0);
    check("reset.empty", 32'(empty), 32'd1);
    check("reset.full", 32'(full), 32'd0);
    check("reset.overflow", 32'(overflow), 32'd0);
    check("reset.rd_data", 32'(rd_data), 32'd0);

    // Error-free records update counters only.
    cyc(2'd1, 4'd0, 1'b0, 1'b0);
    cyc(2'd2, 4'd0, 1'b0, 1'b0);
    cyc(2'd1, 4'd0, 1'b0, 1'b0);
    check_cnt("clean", 16'd3, 16'd2, 16'd1, 16'd0);
    check("clean.empty", 32'(empty), 32'd1);

    // One erroneous record after a clear; idx is the pre-increment record count.
    cyc(2'd0, 4'd0, 1'b0, 1'b1);
    check_cnt("clr1", 16'd0, 16'd0, 16'd0, 16'd0);
    cyc(2'd2, 4'd0, 1'b0, 1'b0);
    cyc(2'd1, 4'b0101, 1'b0, 1'b0);
    check_cnt("err1", 16'd2, 16'd1, 16'd1, 16'd1);
    check("err1.empty", 32'(empty), 32'd0);
    check("err1.head", 32'(rd_data), ent(16'd1, 2'd1, 4'b0101));
    cyc(2'd0, 4'd0, 1'b1, 1'b0);
    check("pop1.empty", 32'(empty), 32'd1);
    check("pop1.rd_data", 32'(rd_data), 32'd0);

    // Pop while empty is a no-op.
    cyc(2'd0, 4'd0, 1'b1, 1'b0);
    check("underflow.empty", 32'(empty), 32'd1);
    check("underflow.rec_cnt", 32'(rec_cnt), 32'd2);

    // Push+pop while empty: push wins, new entry visible.
    cyc(2'd1, 4'b0001, 1'b1, 1'b0);
    check("pp_empty.empty", 32'(empty), 32'd0);
    check("pp_empty.head", 32'(rd_data), ent(16'd2, 2'd1, 4'b0001));
    // Push+pop with one entry: occupancy stays 1, head advances to the new entry.
    cyc(2'd2, 4'b1000, 1'b1, 1'b0);
    check("pp_one.empty", 32'(empty), 32'd0);
    check("pp_one.head", 32'(rd_data), ent(16'd3, 2'd2, 4'b1000));
    cyc(2'd0, 4'd0, 1'b1, 1'b0);
    check("pp_one.drain", 32'(empty), 32'd1);
    check_cnt("pp", 16'd4, 16'd2, 16'd2, 16'd3);

    // Reserved and none verdicts are ignored entirely.
    cyc(2'd3, 4'b1111, 1'b0, 1'b0);
    cyc(2'd0, 4'b1000, 1'b0, 1'b0);
    check_cnt("ignored", 16'd4, 16'd2, 16'd2, 16'd3);
    check("ignored.empty", 32'(empty), 32'd1);

    // Clear together with an erroneous record discards the record.
    cyc(2'd1, 4'b0001, 1'b0, 1'b1);
    check_cnt("clr_rec", 16'd0, 16'd0, 16'd0, 16'd0);
    check("clr_rec.empty", 32'(empty), 32'd1);

    // Nine errors without pops: ninth is dropped and overflow latches.
    for (int i = 0; i < 9; i++) cyc(2'd2, 4'b0010, 1'b0, 1'b0);
    check("ovf.full", 32'(full), 32'd1);
    check("ovf.overflow", 32'(overflow), 32'd1);
    check_cnt("ovf", 16'd9, 16'd0, 16'd9, 16'd9);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf.head%0d", i), 32'(rd_data), ent(16'(i), 2'd2, 4'b0010));
      cyc(2'd0, 4'd0, 1'b1, 1'b0);
    end
    check("ovf.drained", 32'(empty), 32'd1);
    check("ovf.sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop: no overflow, tail gets idx 8.
    cyc(2'd0, 4'd0, 1'b0, 1'b1);
    check("clr2.overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cyc(2'd2, 4'b0010, 1'b0, 1'b0);
    check("fpp.full_before", 32'(full), 32'd1);
    cyc(2'd1, 4'b1000, 1'b1, 1'b0);
    check("fpp.full", 32'(full), 32'd1);
    check("fpp.overflow", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("fpp.head%0d", i), 32'(rd_data), ent(16'(i), 2'd2, 4'b0010));
      cyc(2'd0, 4'd0, 1'b1, 1'b0);
    end
    check("fpp.tail", 32'(rd_data), ent(16'd8, 2'd1, 4'b1000));

`ifdef LOGGER_ERR_HIST_EN
    cyc(2'd0, 4'd0, 1'b0, 1'b1);
    cyc(2'd1, 4'b1001, 1'b0, 1'b0);
    cyc(2'd2, 4'b0001, 1'b0, 1'b0);
    check("hist.h0", 32'(err_hist0), 32'd2);
    check("hist.h1", 32'(err_hist1), 32'd0);
    check("hist.h2", 32'(err_hist2), 32'd0);
    check("hist.h3", 32'(err_hist3), 32'd1);
    check("hist.err_cnt", 32'(err_cnt), 32'd2);
`endif

    // Saturation: 65537 erroneous register records.
    cyc(2'd0, 4'd0, 1'b0, 1'b1);
    format_type = 2'd1;
    error_code  = 4'b0001;
    repeat (65537) @(negedge clk);
    format_type = 2'd0;
    error_code  = 4'd0;
    check_cnt("sat", 16'hFFFF, 16'hFFFF, 16'd0, 16'hFFFF);
    check("sat.overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) cyc(2'd0, 4'd0, 1'b1, 1'b0);
    check("sat.drained", 32'(empty), 32'd1);
    cyc(2'd2, 4'b0100, 1'b0, 1'b0);
    check("sat.idx", 32'(rd_data), ent(16'hFFFF, 2'd2, 4'b0100));
    check_cnt("sat2", 16'hFFFF, 16'hFFFF, 16'd1, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
